// File: rtl/riscoffee_csr_ctrl.sv
// riscoffee_csr_ctrl
// Initiator side of the CSR file port. Accepts one decoded Zicsr instruction,
// reads the addressed CSR (the CSR file has a registered read port), then in
// the write-back cycle returns the old value for rd and issues at most one
// WRITE/SET/CLEAR strobe. Illegal accesses complete with ILLEGAL and no side
// effects.
//
// Handshake: a request transfers on a rising edge where VALID && READY are
// both high. READY is high only in IDLE; the requester keeps VALID and all
// request fields stable until that edge. Request inputs are ignored at all
// other times. DONE is a single-cycle pulse two cycles after the transfer;
// ILLEGAL, RD_WE, RD_IDX_O and RD_DATA are meaningful only while DONE is high.
module riscoffee_csr_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  VALID,
    output logic                  READY,
    input  logic [2:0]            FUNCT3,
    input  logic [ADDR_WIDTH-1:0] ADDR,
    input  logic [DATA_WIDTH-1:0] RS1_DATA,
    input  logic [4:0]            RS1_IDX,
    input  logic [4:0]            RD_IDX,
    input  logic [1:0]            PRIV,
    output logic                  CSR_WRITE,
    output logic                  CSR_SET,
    output logic                  CSR_CLEAR,
    output logic [ADDR_WIDTH-1:0] CSR_ADDR,
    output logic [DATA_WIDTH-1:0] CSR_DATA_IN,
    input  logic [DATA_WIDTH-1:0] CSR_DATA_OUT,
    output logic                  DONE,
    output logic                  ILLEGAL,
    output logic                  RD_WE,
    output logic [4:0]            RD_IDX_O,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic [1:0]            DBG_STATE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WB   = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [4:0]              rs1_idx_q, rs1_idx_d;
    logic [4:0]              rd_idx_q, rd_idx_d;
    logic [1:0]              priv_q, priv_d;
    logic [DATA_WIDTH-1:0]   operand_q, operand_d;

    // Decoded view of the latched instruction.
    logic write_issue;
    logic bad_funct3;
    logic priv_fault;
    logic ro_fault;
    logic illegal;
    logic wb_active;
    logic legal_write;

    // State and latched request fields; reset clears everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            funct3_q  <= '0;
            addr_q    <= '0;
            rs1_idx_q <= '0;
            rd_idx_q  <= '0;
            priv_q    <= '0;
            operand_q <= '0;
        end else begin
            state_q   <= state_d;
            funct3_q  <= funct3_d;
            addr_q    <= addr_d;
            rs1_idx_q <= rs1_idx_d;
            rd_idx_q  <= rd_idx_d;
            priv_q    <= priv_d;
            operand_q <= operand_d;
        end
    end

    // Next state and request capture: fields are only sampled on acceptance.
    always_comb begin
        state_d   = state_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        rs1_idx_d = rs1_idx_q;
        rd_idx_d  = rd_idx_q;
        priv_d    = priv_q;
        operand_d = operand_q;
        case (state_q)
            S_IDLE: begin
                if (VALID) begin
                    funct3_d  = FUNCT3;
                    addr_d    = ADDR;
                    rs1_idx_d = RS1_IDX;
                    rd_idx_d  = RD_IDX;
                    priv_d    = PRIV;
                    // Immediate forms use the rs1 field as a zero-extended zimm.
                    operand_d = FUNCT3[2] ? {{(DATA_WIDTH-5){1'b0}}, RS1_IDX}
                                          : RS1_DATA;
                    state_d   = S_RD;
                end
            end
            S_RD:    state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Legality: RW/RWI always write; set/clear forms write only with a nonzero
    // rs1/zimm field, so a read-only CSR can still be read through them.
    always_comb begin
        write_issue = (funct3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0);
        bad_funct3  = (funct3_q[1:0] == 2'b00);
        priv_fault  = (addr_q[9:8] > priv_q);
        ro_fault    = (addr_q[11:10] == 2'b11) && write_issue;
        illegal     = bad_funct3 || priv_fault || ro_fault;
    end

    // Port outputs; all side-effecting pulses are suppressed while RST is high
    // so an access aborted by reset never updates the CSR file or rd.
    always_comb begin
        wb_active   = (state_q == S_WB) && !RST;
        legal_write = wb_active && !illegal && write_issue;

        READY       = (state_q == S_IDLE);
        DONE        = wb_active;
        ILLEGAL     = wb_active && illegal;
        RD_WE       = wb_active && !illegal && (rd_idx_q != 5'd0);
        CSR_WRITE   = legal_write && (funct3_q[1:0] == 2'b01);
        CSR_SET     = legal_write && (funct3_q[1:0] == 2'b10);
        CSR_CLEAR   = legal_write && (funct3_q[1:0] == 2'b11);

        CSR_ADDR    = '0;
        CSR_DATA_IN = '0;
        RD_DATA     = '0;
        RD_IDX_O    = '0;
        if (state_q != S_IDLE) begin
            CSR_ADDR = addr_q;
        end
        if (state_q == S_WB) begin
            // The registered read data is the pre-update value this cycle.
            CSR_DATA_IN = operand_q;
            RD_DATA     = CSR_DATA_OUT;
            RD_IDX_O    = rd_idx_q;
        end

        DBG_STATE   = state_q;
    end

endmodule

// File: tb/tb_riscoffee_csr_ctrl.sv
// Bench for riscoffee_csr_ctrl: a behavioural CSR file with a registered read
// port sits on the CSR side; table vectors carry hand-computed expectations.
module tb_riscoffee_csr_ctrl;

  logic        clk;
  logic        rst;
  logic        valid;
  logic        ready;
  logic [2:0]  funct3;
  logic [11:0] addr;
  logic [31:0] rs1_data;
  logic [4:0]  rs1_idx;
  logic [4:0]  rd_idx;
  logic [1:0]  priv;
  logic        csr_write;
  logic        csr_set;
  logic        csr_clear;
  logic [11:0] csr_addr;
  logic [31:0] csr_data_in;
  logic [31:0] csr_data_out;
  logic        done;
  logic        illegal;
  logic        rd_we;
  logic [4:0]  rd_idx_o;
  logic [31:0] rd_data;
  logic [1:0]  dbg_state;

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  riscoffee_csr_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
    .CLK(clk), .RST(rst), .VALID(valid), .READY(ready),
    .FUNCT3(funct3), .ADDR(addr), .RS1_DATA(rs1_data), .RS1_IDX(rs1_idx),
    .RD_IDX(rd_idx), .PRIV(priv),
    .CSR_WRITE(csr_write), .CSR_SET(csr_set), .CSR_CLEAR(csr_clear),
    .CSR_ADDR(csr_addr), .CSR_DATA_IN(csr_data_in), .CSR_DATA_OUT(csr_data_out),
    .DONE(done), .ILLEGAL(illegal), .RD_WE(rd_we), .RD_IDX_O(rd_idx_o),
    .RD_DATA(rd_data), .DBG_STATE(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // CSR file model: registered read, updates at the clock edge
  logic        mem_init;
  logic [31:0] mem [0:4095];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
      mem[12'h340] <= 32'h12345678;
      mem[12'h300] <= 32'h0000000F;
      mem[12'hC00] <= 32'h11110000;
      mem[12'h100] <= 32'h00000055;
    end else begin
      if (csr_write) mem[csr_addr] <= csr_data_in;
      if (csr_set)   mem[csr_addr] <= mem[csr_addr] | csr_data_in;
      if (csr_clear) mem[csr_addr] <= mem[csr_addr] & ~csr_data_in;
    end
    csr_data_out <= mem[csr_addr];
  end

  // vector table
  typedef struct {
    logic [2:0]  f3;
    logic [11:0] a;
    logic [31:0] d;
    logic [4:0]  s;
    logic [4:0]  r;
    logic [1:0]  p;
    logic [2:0]  e_strobe;   // {write, set, clear}
    logic        e_ill;
    logic        e_rdwe;
    logic [31:0] e_din;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic [2:0] f3, logic [11:0] a, logic [31:0] d,
                              logic [4:0] s, logic [4:0] r, logic [1:0] p,
                              logic [2:0] e_strobe, logic e_ill, logic e_rdwe,
                              logic [31:0] e_din, logic [31:0] e_rdata);
    vec_t v;
    v.f3 = f3; v.a = a; v.d = d; v.s = s; v.r = r; v.p = p;
    v.e_strobe = e_strobe; v.e_ill = e_ill; v.e_rdwe = e_rdwe;
    v.e_din = e_din; v.e_rdata = e_rdata;
    return v;
  endfunction

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: one request through accept, RD and WB
  task automatic run_vec(input int idx, input vec_t v);
    int got;
    @(negedge clk);
    funct3 = v.f3; addr = v.a; rs1_data = v.d; rs1_idx = v.s; rd_idx = v.r; priv = v.p;
    valid = 1'b1;
    if (v.e_rdwe) exp_q.push_back(v.e_rdata);
    #1;
    chk($sformatf("v%0d ready_idle", idx), {31'b0, ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    funct3 = 3'($urandom_range(0, 7));
    addr = 12'($urandom_range(0, 4095));
    rs1_data = $urandom;
    rs1_idx = 5'($urandom_range(0, 31));
    rd_idx = 5'($urandom_range(0, 31));
    #1;
    chk($sformatf("v%0d rd_phase", idx),
        {26'b0, ready, done, csr_write, csr_set, csr_clear, rd_we}, 32'd0);
    chk($sformatf("v%0d rd_addr", idx), {20'b0, csr_addr}, {20'b0, v.a});
    got = 0;
    for (int n = 2; n <= 6; n++) begin
      @(negedge clk);
      #1;
      if (done) begin
        got = n;
        break;
      end
    end
    chk($sformatf("v%0d latency", idx), got, 2);
    if (got != 0) begin
      chk($sformatf("v%0d strobes", idx), {29'b0, csr_write, csr_set, csr_clear},
          {29'b0, v.e_strobe});
      chk($sformatf("v%0d illegal", idx), {31'b0, illegal}, {31'b0, v.e_ill});
      chk($sformatf("v%0d rd_we", idx), {31'b0, rd_we}, {31'b0, v.e_rdwe});
      chk($sformatf("v%0d wb_addr", idx), {20'b0, csr_addr}, {20'b0, v.a});
      if (v.e_strobe != 3'b000)
        chk($sformatf("v%0d data_in", idx), csr_data_in, v.e_din);
      if (v.e_rdwe && exp_q.size() > 0) begin
        chk($sformatf("v%0d rd_idx", idx), {27'b0, rd_idx_o}, {27'b0, v.r});
        chk($sformatf("v%0d rd_data", idx), rd_data, exp_q.pop_front());
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    mem_init = 1'b1;
    rst = 1'b1;
    valid = 1'b1;
    funct3 = 3'b001; addr = 12'h340; rs1_data = 32'h00000BAD;
    rs1_idx = 5'd7; rd_idx = 5'd5; priv = 2'b11;

    //            f3      addr     rs1_data      s   r   p     {w,s,c} ill we din           rdata
    vecs[0]  = mk(3'b001, 12'h340, 32'hDEADBEEF, 7,  5,  2'd3, 3'b100, 0, 1, 32'hDEADBEEF, 32'h12345678);
    vecs[1]  = mk(3'b010, 12'h340, 32'h0000FFFF, 0,  6,  2'd3, 3'b000, 0, 1, 32'h0,        32'hDEADBEEF);
    vecs[2]  = mk(3'b111, 12'h300, 32'hFFFFFFFF, 5,  0,  2'd3, 3'b001, 0, 0, 32'h5,        32'h0);
    vecs[3]  = mk(3'b010, 12'h300, 32'h0,        0,  1,  2'd3, 3'b000, 0, 1, 32'h0,        32'h0000000A);
    vecs[4]  = mk(3'b001, 12'hC00, 32'h1,        2,  3,  2'd3, 3'b000, 1, 0, 32'h0,        32'h0);
    vecs[5]  = mk(3'b010, 12'hC00, 32'h0,        0,  3,  2'd3, 3'b000, 0, 1, 32'h0,        32'h11110000);
    vecs[6]  = mk(3'b010, 12'h300, 32'h0,        0,  4,  2'd0, 3'b000, 1, 0, 32'h0,        32'h0);
    vecs[7]  = mk(3'b100, 12'h340, 32'h0,        1,  2,  2'd3, 3'b000, 1, 0, 32'h0,        32'h0);
    vecs[8]  = mk(3'b010, 12'h300, 32'h00000030, 1,  8,  2'd3, 3'b010, 0, 1, 32'h30,       32'h0000000A);
    vecs[9]  = mk(3'b110, 12'h300, 32'hFFFFFFFF, 0,  9,  2'd3, 3'b000, 0, 1, 32'h0,        32'h0000003A);
    vecs[10] = mk(3'b101, 12'h340, 32'hFFFFFFFF, 0,  0,  2'd3, 3'b100, 0, 0, 32'h0,        32'h0);
    vecs[11] = mk(3'b011, 12'h340, 32'h0000000F, 3,  10, 2'd3, 3'b001, 0, 1, 32'hF,        32'h0);
    vecs[12] = mk(3'b010, 12'h100, 32'h0,        0,  11, 2'd1, 3'b000, 0, 1, 32'h0,        32'h00000055);
    vecs[13] = mk(3'b010, 12'h340, 32'h0,        0,  12, 2'd1, 3'b000, 1, 0, 32'h0,        32'h0);
    vecs[14] = mk(3'b000, 12'h340, 32'h0,        1,  1,  2'd3, 3'b000, 1, 0, 32'h0,        32'h0);
    vecs[15] = mk(3'b111, 12'hC00, 32'h0,        0,  7,  2'd3, 3'b000, 0, 1, 32'h0,        32'h11110000);

    // reset held two cycles with VALID high
    @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    #1;
    chk("rst1 pulses", {26'b0, done, csr_write, csr_set, csr_clear, rd_we, illegal}, 32'd0);
    chk("rst1 ready", {31'b0, ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst2 pulses", {26'b0, done, csr_write, csr_set, csr_clear, rd_we, illegal}, 32'd0);
    rst = 1'b0;
    valid = 1'b0;
    #1;
    chk("rst ready", {31'b0, ready}, 32'd1);
    chk("rst csr_addr", {20'b0, csr_addr}, 32'd0);
    chk("rst rd_data", rd_data, 32'd0);
    chk("rst rd_idx_o", {27'b0, rd_idx_o}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_rst idle%0d", k), {30'b0, done, ready}, 32'd1);
    end
    chk("rst csr unchanged", mem[12'h340], 32'h12345678);

    // table vectors
    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);
    chk("final 0x300", mem[12'h300], 32'h0000003A);
    chk("final 0xC00", mem[12'hC00], 32'h11110000);
    chk("final 0x340", mem[12'h340], 32'h00000000);

    // reset pulsed during WB of a CSRRW
    @(negedge clk);
    funct3 = 3'b001; addr = 12'h340; rs1_data = 32'h00000099;
    rs1_idx = 5'd4; rd_idx = 5'd5; priv = 2'b11; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    #1;
    chk("midop reached wb", {30'b0, dbg_state}, 32'd2);
    rst = 1'b1;
    #1;
    chk("midop gated", {27'b0, done, csr_write, csr_set, csr_clear, rd_we}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midop ready", {31'b0, ready}, 32'd1);
    chk("midop csr unchanged", mem[12'h340], 32'h00000000);

    // VALID held for three CSRRS reads: DONE in cycles 2, 5, 8
    @(negedge clk);
    funct3 = 3'b010; addr = 12'h300; rs1_data = 32'hFFFFFFFF;
    rs1_idx = 5'd0; rd_idx = 5'd1; priv = 2'b11; valid = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("b2b done c%0d", k), {31'b0, done},
          {31'b0, (k == 2 || k == 5 || k == 8)});
      if (k == 2 || k == 5 || k == 8)
        chk($sformatf("b2b rd_data c%0d", k), rd_data, 32'h0000003A);
      if (k == 8) valid = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
